// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: consumer-side engine for a FIFO with a one-cycle
// registered read port. Issues read strobes, captures the returning words
// into a 2-entry in-order buffer, and presents them on a valid/ready stream
// with burst framing (m_last) and a handshake counter.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  rd,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic [CNT_WIDTH-1:0]  words_sent
);

  // Beat index is 8 bits wide because BURST_LEN is limited to 1..255.
  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [7:0]            beat_q, beat_d;
  logic [DATA_WIDTH-1:0] data0_q, data0_d, data1_q, data1_d;
  logic                  last0_q, last0_d, last1_q, last1_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  run_q, run_d;

  logic       pop;
  logic       cap;
  logic       cap_last;
  logic [2:0] pending;

  // Handshake, capture and read-strobe decisions. A read is only issued when
  // the buffer is guaranteed to have room for the word when it returns.
  // run_q holds reads off while reset is asserted (and for the first edge
  // after release), so the strobe drops the moment rst_n falls.
  always_comb begin
    pop      = (occ_q != 2'd0) & m_ready;
    cap      = inflight_q;
    cap_last = (beat_q == LAST_BEAT);
    pending  = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
    rd       = run_q & enable & ~fifo_empty & (pending < 3'd2);
  end

  // Next-state for buffer occupancy/contents, beat index and counter.
  always_comb begin
    occ_d      = occ_q;
    inflight_d = rd;
    beat_d     = beat_q;
    data0_d    = data0_q;
    data1_d    = data1_q;
    last0_d    = last0_q;
    last1_d    = last1_q;
    cnt_d      = cnt_q;
    run_d      = 1'b1;

    if (cap) begin
      beat_d = cap_last ? 8'd0 : beat_q + 8'd1;
    end

    if (pop) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end

    case ({cap, pop})
      // Capture only: append behind the current contents.
      2'b10: begin
        if (occ_q == 2'd0) begin
          data0_d = fifo_data;
          last0_d = cap_last;
        end else begin
          data1_d = fifo_data;
          last1_d = cap_last;
        end
        occ_d = occ_q + 2'd1;
      end
      // Pop only: shift the second entry into the head.
      2'b01: begin
        data0_d = data1_q;
        last0_d = last1_q;
        occ_d   = occ_q - 2'd1;
      end
      // Pop and capture together: occupancy unchanged, order preserved.
      2'b11: begin
        if (occ_q == 2'd1) begin
          data0_d = fifo_data;
          last0_d = cap_last;
        end else begin
          data0_d = data1_q;
          last0_d = last1_q;
          data1_d = fifo_data;
          last1_d = cap_last;
        end
      end
      default: ;
    endcase
  end

  // State registers; any word in flight at reset is simply dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      beat_q     <= 8'd0;
      data0_q    <= '0;
      data1_q    <= '0;
      last0_q    <= 1'b0;
      last1_q    <= 1'b0;
      cnt_q      <= '0;
      run_q      <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      beat_q     <= beat_d;
      data0_q    <= data0_d;
      data1_q    <= data1_d;
      last0_q    <= last0_d;
      last1_q    <= last1_d;
      cnt_q      <= cnt_d;
      run_q      <= run_d;
    end
  end

  // Stream outputs come straight from the head register.
  always_comb begin
    m_valid    = (occ_q != 2'd0);
    m_data     = data0_q;
    m_last     = last0_q & (occ_q != 2'd0);
    words_sent = cnt_q;
  end

endmodule
